// File: rtl/hr_bridge_q_pkg.sv
// Shared constants for the hierarchical-ring bridge: flit geometry, field offsets,
// the empty-slot encoding and a saturating add used by the deflection counters.
package hr_bridge_q_pkg;

    localparam int CONTROL_W  = 144;
    localparam int VALID_BIT  = 0;
    localparam int DEF_DST_LO = 4;
    localparam int DEF_RING_W = 2;
    localparam int DEFL_W     = 16;

    localparam logic [CONTROL_W-1:0] EMPTY_FLIT = '0;
    localparam logic [DEFL_W-1:0]    DEFL_MAX   = '1;

    // Index width that stays legal even for a single-channel ring.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic logic [DEFL_W-1:0] sat_add(input logic [DEFL_W-1:0] base, input int inc);
        int sum;
        sum = int'(base) + inc;
        if (sum > int'(DEFL_MAX)) begin
            return DEFL_MAX;
        end
        return DEFL_W'(sum);
    endfunction

endpackage

// File: rtl/hrb_fifo.sv
// Synchronous transfer FIFO; full and empty reflect the occupancy at the start of
// the cycle, so a push into a full FIFO is dropped even when a pop happens alongside.
module hrb_fifo #(
    parameter int W     = 144,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [W-1:0]             din,
    output logic [W-1:0]             dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] cnt;
    logic          do_push;
    logic          do_pop;

    assign full    = (cnt == CW'(DEPTH));
    assign empty   = (cnt == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];
    assign count   = cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            cnt <= cnt + CW'(do_push) - CW'(do_pop);
        end
    end

    // Storage needs no reset: a cleared count makes stale entries unreachable.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

endmodule

// File: rtl/hr_bridge_q.sv
// Hierarchical-ring bridge: ejects cross-ring flits into per-direction transfer FIFOs
// and re-injects them into free slots on the other ring. Define HRB_STATS_EN for deflection counters.
module hr_bridge_q
    import hr_bridge_q_pkg::*;
#(
    parameter int FLIT_W     = CONTROL_W,
    parameter int N_LOCAL    = 2,
    parameter int N_GLOBAL   = 4,
    parameter int FIFO_DEPTH = 4,
    parameter int RING_W     = DEF_RING_W,
    parameter int DST_LO     = DEF_DST_LO,
    parameter int RING_ID    = 0
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [N_LOCAL*FLIT_W-1:0]       port_l_i,
    input  logic [N_GLOBAL*FLIT_W-1:0]      port_g_i,
    output logic [N_LOCAL*FLIT_W-1:0]       port_l_o,
    output logic [N_GLOBAL*FLIT_W-1:0]      port_g_o,
    output logic [$clog2(FIFO_DEPTH):0]     l2g_cnt_o,
    output logic [$clog2(FIFO_DEPTH):0]     g2l_cnt_o,
    output logic [DEFL_W-1:0]               defl_l_o,
    output logic [DEFL_W-1:0]               defl_g_o
);

    localparam int MAX_N = (N_LOCAL > N_GLOBAL) ? N_LOCAL : N_GLOBAL;
    localparam int LW    = idx_w(N_LOCAL);
    localparam int GW    = idx_w(N_GLOBAL);

    localparam logic [RING_W-1:0] RING_ID_V  = RING_W'(RING_ID);
    localparam logic [FLIT_W-1:0] EMPTY_SLOT = FLIT_W'(EMPTY_FLIT);

    // First set bit of req at or after ptr, wrapping within n channels; -1 when none.
    function automatic int rr_pick(input logic [MAX_N-1:0] req, input int ptr, input int n);
        int idx;
        int pick;
        pick = -1;
        for (int i = MAX_N - 1; i >= 0; i--) begin
            if (i < n) begin
                idx = ptr + i;
                if (idx >= n) begin
                    idx = idx - n;
                end
                if (req[idx]) begin
                    pick = idx;
                end
            end
        end
        return pick;
    endfunction

    logic [FLIT_W-1:0] l_in   [N_LOCAL];
    logic [FLIT_W-1:0] l_keep [N_LOCAL];
    logic [FLIT_W-1:0] l_next [N_LOCAL];
    logic [FLIT_W-1:0] g_in   [N_GLOBAL];
    logic [FLIT_W-1:0] g_keep [N_GLOBAL];
    logic [FLIT_W-1:0] g_next [N_GLOBAL];

    logic [MAX_N-1:0]  l_req;
    logic [MAX_N-1:0]  l_free;
    logic [MAX_N-1:0]  g_req;
    logic [MAX_N-1:0]  g_free;

    logic [LW-1:0]     l_ptr;
    logic [LW-1:0]     l_inj;
    logic [GW-1:0]     g_ptr;
    logic [GW-1:0]     g_inj;

    int                l_win;
    int                l_slot;
    int                g_win;
    int                g_slot;

    logic              l2g_push;
    logic              l2g_pop;
    logic              l2g_full;
    logic              l2g_empty;
    logic [FLIT_W-1:0] l2g_din;
    logic [FLIT_W-1:0] l2g_head;

    logic              g2l_push;
    logic              g2l_pop;
    logic              g2l_full;
    logic              g2l_empty;
    logic [FLIT_W-1:0] g2l_din;
    logic [FLIT_W-1:0] g2l_head;

    // Local side: eject flits bound for another ring, then fill a free slot from G2L.
    always_comb begin
        l_req   = '0;
        l_free  = '0;
        l2g_din = EMPTY_SLOT;
        for (int k = 0; k < N_LOCAL; k++) begin
            l_in[k]  = port_l_i[k*FLIT_W +: FLIT_W];
            l_req[k] = l_in[k][VALID_BIT] && (l_in[k][DST_LO +: RING_W] != RING_ID_V);
        end
        l_win    = rr_pick(l_req, int'(l_ptr), N_LOCAL);
        l2g_push = (l_win >= 0) && !l2g_full;
        for (int k = 0; k < N_LOCAL; k++) begin
            l_keep[k] = (l2g_push && (k == l_win)) ? EMPTY_SLOT : l_in[k];
            l_free[k] = !l_keep[k][VALID_BIT];
            if (k == l_win) begin
                l2g_din = l_in[k];
            end
        end
        l_slot  = g2l_empty ? -1 : rr_pick(l_free, int'(l_inj), N_LOCAL);
        g2l_pop = (l_slot >= 0);
        for (int k = 0; k < N_LOCAL; k++) begin
            l_next[k] = (k == l_slot) ? g2l_head : l_keep[k];
        end
    end

    // Global side mirrors the local side with the eject condition inverted.
    always_comb begin
        g_req   = '0;
        g_free  = '0;
        g2l_din = EMPTY_SLOT;
        for (int k = 0; k < N_GLOBAL; k++) begin
            g_in[k]  = port_g_i[k*FLIT_W +: FLIT_W];
            g_req[k] = g_in[k][VALID_BIT] && (g_in[k][DST_LO +: RING_W] == RING_ID_V);
        end
        g_win    = rr_pick(g_req, int'(g_ptr), N_GLOBAL);
        g2l_push = (g_win >= 0) && !g2l_full;
        for (int k = 0; k < N_GLOBAL; k++) begin
            g_keep[k] = (g2l_push && (k == g_win)) ? EMPTY_SLOT : g_in[k];
            g_free[k] = !g_keep[k][VALID_BIT];
            if (k == g_win) begin
                g2l_din = g_in[k];
            end
        end
        g_slot  = l2g_empty ? -1 : rr_pick(g_free, int'(g_inj), N_GLOBAL);
        l2g_pop = (g_slot >= 0);
        for (int k = 0; k < N_GLOBAL; k++) begin
            g_next[k] = (k == g_slot) ? l2g_head : g_keep[k];
        end
    end

    hrb_fifo #(
        .W     (FLIT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_l2g (
        .clk   (clk),
        .rst   (rst),
        .push  (l2g_push),
        .pop   (l2g_pop),
        .din   (l2g_din),
        .dout  (l2g_head),
        .full  (l2g_full),
        .empty (l2g_empty),
        .count (l2g_cnt_o)
    );

    hrb_fifo #(
        .W     (FLIT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_g2l (
        .clk   (clk),
        .rst   (rst),
        .push  (g2l_push),
        .pop   (g2l_pop),
        .din   (g2l_din),
        .dout  (g2l_head),
        .full  (g2l_full),
        .empty (g2l_empty),
        .count (g2l_cnt_o)
    );

    // Eject pointers move only on an accepted push, inject pointers only on a pop.
    always_ff @(posedge clk) begin
        if (rst) begin
            l_ptr    <= '0;
            l_inj    <= '0;
            g_ptr    <= '0;
            g_inj    <= '0;
            port_l_o <= '0;
            port_g_o <= '0;
        end else begin
            if (l2g_push) begin
                l_ptr <= LW'((l_win + 1) % N_LOCAL);
            end
            if (g2l_pop) begin
                l_inj <= LW'((l_slot + 1) % N_LOCAL);
            end
            if (g2l_push) begin
                g_ptr <= GW'((g_win + 1) % N_GLOBAL);
            end
            if (l2g_pop) begin
                g_inj <= GW'((g_slot + 1) % N_GLOBAL);
            end
            for (int k = 0; k < N_LOCAL; k++) begin
                port_l_o[k*FLIT_W +: FLIT_W] <= l_next[k];
            end
            for (int k = 0; k < N_GLOBAL; k++) begin
                port_g_o[k*FLIT_W +: FLIT_W] <= g_next[k];
            end
        end
    end

`ifdef HRB_STATS_EN
    logic [DEFL_W-1:0] defl_l_q;
    logic [DEFL_W-1:0] defl_g_q;

    // Every requester that did not get its flit into the FIFO stayed on the ring.
    always_ff @(posedge clk) begin
        if (rst) begin
            defl_l_q <= '0;
            defl_g_q <= '0;
        end else begin
            defl_l_q <= sat_add(defl_l_q, $countones(l_req) - int'(l2g_push));
            defl_g_q <= sat_add(defl_g_q, $countones(g_req) - int'(g2l_push));
        end
    end

    assign defl_l_o = defl_l_q;
    assign defl_g_o = defl_g_q;
`else
    assign defl_l_o = '0;
    assign defl_g_o = '0;
`endif

endmodule

// File: tb/tb_hr_bridge_q.sv
// Self-checking bench for hr_bridge_q: directed scenarios plus random traffic,
// compared cycle by cycle against a queue-based model of the bridge rules.
module tb_hr_bridge_q;

    localparam int FLIT_W     = 144;
    localparam int N_LOCAL    = 2;
    localparam int N_GLOBAL   = 4;
    localparam int FIFO_DEPTH = 4;
    localparam int RING_W     = 2;
    localparam int DST_LO     = 4;
    localparam int RING_ID    = 0;
    localparam int CW         = $clog2(FIFO_DEPTH) + 1;
    localparam int WIDE       = N_GLOBAL * FLIT_W;
    localparam logic [WIDE-1:0] ZERO = '0;

    logic                       clk = 1'b0;
    logic                       rst;
    logic [N_LOCAL*FLIT_W-1:0]  port_l_i;
    logic [N_GLOBAL*FLIT_W-1:0] port_g_i;
    logic [N_LOCAL*FLIT_W-1:0]  port_l_o;
    logic [N_GLOBAL*FLIT_W-1:0] port_g_o;
    logic [CW-1:0]              l2g_cnt_o;
    logic [CW-1:0]              g2l_cnt_o;
    logic [15:0]                defl_l_o;
    logic [15:0]                defl_g_o;

    always #5 clk = ~clk;

    hr_bridge_q #(
        .FLIT_W     (FLIT_W),
        .N_LOCAL    (N_LOCAL),
        .N_GLOBAL   (N_GLOBAL),
        .FIFO_DEPTH (FIFO_DEPTH),
        .RING_W     (RING_W),
        .DST_LO     (DST_LO),
        .RING_ID    (RING_ID)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .port_l_i  (port_l_i),
        .port_g_i  (port_g_i),
        .port_l_o  (port_l_o),
        .port_g_o  (port_g_o),
        .l2g_cnt_o (l2g_cnt_o),
        .g2l_cnt_o (g2l_cnt_o),
        .defl_l_o  (defl_l_o),
        .defl_g_o  (defl_g_o)
    );

    logic [FLIT_W-1:0] in_l  [N_LOCAL];
    logic [FLIT_W-1:0] in_g  [N_GLOBAL];
    logic [FLIT_W-1:0] exp_l [N_LOCAL];
    logic [FLIT_W-1:0] exp_g [N_GLOBAL];
    logic [FLIT_W-1:0] q_l2g [$];
    logic [FLIT_W-1:0] q_g2l [$];
    int m_ptr_l, m_ptr_g, m_inj_l, m_inj_g;
    int m_defl_l, m_defl_g;
    int checks = 0;
    int errors = 0;

    function automatic logic [FLIT_W-1:0] make_flit(input int dst);
        logic [159:0]      r;
        logic [FLIT_W-1:0] f;
        r = {$urandom, $urandom, $urandom, $urandom, $urandom};
        f = r[FLIT_W-1:0];
        f[0] = 1'b1;
        f[DST_LO +: RING_W] = RING_W'(dst);
        return f;
    endfunction

    function automatic logic [FLIT_W-1:0] rand_slot();
        if ($urandom_range(0, 2) == 0) begin
            return '0;
        end
        return make_flit(int'($urandom_range(0, 3)));
    endfunction

    function automatic int exp_defl(input int m);
`ifdef HRB_STATS_EN
        return m;
`else
        return (m >= 0) ? 0 : 0;
`endif
    endfunction

    function automatic int sat16(input int v);
        return (v > 65535) ? 65535 : v;
    endfunction

    task automatic check_output(input string tag, input logic [WIDE-1:0] obs, input logic [WIDE-1:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic clear_inputs();
        for (int k = 0; k < N_LOCAL; k++) in_l[k] = '0;
        for (int k = 0; k < N_GLOBAL; k++) in_g[k] = '0;
    endtask

    task automatic randomize_inputs();
        for (int k = 0; k < N_LOCAL; k++) in_l[k] = rand_slot();
        for (int k = 0; k < N_GLOBAL; k++) in_g[k] = rand_slot();
    endtask

    // One cycle of bridge behaviour expressed with queues and modular arithmetic.
    task automatic model_step();
        logic [FLIT_W-1:0] nl [N_LOCAL];
        logic [FLIT_W-1:0] ng [N_GLOBAL];
        int l2g_start, g2l_start, win, slot, nreq, c;
        if (rst) begin
            q_l2g.delete();
            q_g2l.delete();
            m_ptr_l = 0; m_ptr_g = 0; m_inj_l = 0; m_inj_g = 0;
            m_defl_l = 0; m_defl_g = 0;
            for (int k = 0; k < N_LOCAL; k++) exp_l[k] = '0;
            for (int k = 0; k < N_GLOBAL; k++) exp_g[k] = '0;
            return;
        end
        l2g_start = q_l2g.size();
        g2l_start = q_g2l.size();
        nl = in_l;
        ng = in_g;
        win = -1; nreq = 0;
        for (int i = 0; i < N_LOCAL; i++) begin
            c = (m_ptr_l + i) % N_LOCAL;
            if (nl[c][0] && nl[c][DST_LO +: RING_W] != RING_W'(RING_ID)) begin
                nreq++;
                if (win < 0) win = c;
            end
        end
        if (win >= 0 && l2g_start < FIFO_DEPTH) begin
            q_l2g.push_back(nl[win]);
            nl[win] = '0;
            m_ptr_l = (win + 1) % N_LOCAL;
            nreq--;
        end
        m_defl_l = sat16(m_defl_l + nreq);
        win = -1; nreq = 0;
        for (int i = 0; i < N_GLOBAL; i++) begin
            c = (m_ptr_g + i) % N_GLOBAL;
            if (ng[c][0] && ng[c][DST_LO +: RING_W] == RING_W'(RING_ID)) begin
                nreq++;
                if (win < 0) win = c;
            end
        end
        if (win >= 0 && g2l_start < FIFO_DEPTH) begin
            q_g2l.push_back(ng[win]);
            ng[win] = '0;
            m_ptr_g = (win + 1) % N_GLOBAL;
            nreq--;
        end
        m_defl_g = sat16(m_defl_g + nreq);
        if (g2l_start > 0) begin
            slot = -1;
            for (int i = 0; i < N_LOCAL; i++) begin
                c = (m_inj_l + i) % N_LOCAL;
                if (!nl[c][0] && slot < 0) slot = c;
            end
            if (slot >= 0) begin
                nl[slot] = q_g2l.pop_front();
                m_inj_l = (slot + 1) % N_LOCAL;
            end
        end
        if (l2g_start > 0) begin
            slot = -1;
            for (int i = 0; i < N_GLOBAL; i++) begin
                c = (m_inj_g + i) % N_GLOBAL;
                if (!ng[c][0] && slot < 0) slot = c;
            end
            if (slot >= 0) begin
                ng[slot] = q_l2g.pop_front();
                m_inj_g = (slot + 1) % N_GLOBAL;
            end
        end
        exp_l = nl;
        exp_g = ng;
    endtask

    task automatic check_all();
        logic [WIDE-1:0] el;
        logic [WIDE-1:0] eg;
        el = '0;
        eg = '0;
        for (int k = 0; k < N_LOCAL; k++) el[k*FLIT_W +: FLIT_W] = exp_l[k];
        for (int k = 0; k < N_GLOBAL; k++) eg[k*FLIT_W +: FLIT_W] = exp_g[k];
        check_output("port_l_o", WIDE'(port_l_o), el);
        check_output("port_g_o", port_g_o, eg);
        check_output("l2g_cnt", WIDE'(l2g_cnt_o), WIDE'(q_l2g.size()));
        check_output("g2l_cnt", WIDE'(g2l_cnt_o), WIDE'(q_g2l.size()));
        check_output("defl_l", WIDE'(defl_l_o), WIDE'(exp_defl(m_defl_l)));
        check_output("defl_g", WIDE'(defl_g_o), WIDE'(exp_defl(m_defl_g)));
    endtask

    // Drive at the falling edge, advance one rising edge, sample at the next falling edge.
    task automatic apply_stimulus();
        for (int k = 0; k < N_LOCAL; k++) port_l_i[k*FLIT_W +: FLIT_W] = in_l[k];
        for (int k = 0; k < N_GLOBAL; k++) port_g_i[k*FLIT_W +: FLIT_W] = in_g[k];
        model_step();
        @(posedge clk);
        @(negedge clk);
        check_all();
    endtask

    initial begin
        logic [FLIT_W-1:0] f;
        logic [FLIT_W-1:0] arb_first;
        rst = 1'b1;
        port_l_i = '0;
        port_g_i = '0;
        clear_inputs();
        @(negedge clk);

        $display("[TB] reset held with traffic on all inputs");
        for (int c = 0; c < 2; c++) begin
            randomize_inputs();
            apply_stimulus();
        end
        check_output("rst_port_l", WIDE'(port_l_o), ZERO);
        check_output("rst_port_g", port_g_o, ZERO);
        rst = 1'b0;
        clear_inputs();
        apply_stimulus();
        check_output("rel_l2g_cnt", WIDE'(l2g_cnt_o), ZERO);
        check_output("rel_g2l_cnt", WIDE'(g2l_cnt_o), ZERO);

        $display("[TB] pass-through on local ch0");
        in_l[0] = make_flit(RING_ID);
        f = in_l[0];
        apply_stimulus();
        check_output("pass_ch0", WIDE'(port_l_o[FLIT_W-1:0]), WIDE'(f));
        check_output("pass_l2g_cnt", WIDE'(l2g_cnt_o), ZERO);

        $display("[TB] eject from local ch1 and inject on global ch0");
        clear_inputs();
        in_l[1] = make_flit(2);
        f = in_l[1];
        apply_stimulus();
        check_output("eject_l2g_cnt", WIDE'(l2g_cnt_o), WIDE'(1));
        clear_inputs();
        apply_stimulus();
        check_output("inject_g_ch0", WIDE'(port_g_o[FLIT_W-1:0]), WIDE'(f));
        check_output("inject_l2g_cnt", WIDE'(l2g_cnt_o), ZERO);

        $display("[TB] arbitration with the global ring fully occupied");
        arb_first = '0;
        for (int c = 0; c < 6; c++) begin
            for (int k = 0; k < N_GLOBAL; k++) in_g[k] = make_flit(1);
            for (int k = 0; k < N_LOCAL; k++) in_l[k] = make_flit(3);
            if (c == 0) arb_first = in_l[0];
            apply_stimulus();
            if (c < 4) begin
                check_output("arb_winner_empty", WIDE'(port_l_o[(c % 2)*FLIT_W +: FLIT_W]), ZERO);
                check_output("arb_loser_pass", WIDE'(port_l_o[(1 - c % 2)*FLIT_W +: FLIT_W]),
                             WIDE'(in_l[1 - c % 2]));
            end
            check_output("arb_l2g_cnt", WIDE'(l2g_cnt_o), WIDE'((c < 4) ? c + 1 : 4));
            check_output("arb_defl_l", WIDE'(defl_l_o), WIDE'(exp_defl((c < 4) ? c + 1 : 4 + 2 * (c - 3))));
        end

        $display("[TB] full FIFO with simultaneous pop and new eject request");
        in_l[0] = make_flit(3);
        in_l[1] = make_flit(RING_ID);
        for (int k = 0; k < N_GLOBAL; k++) in_g[k] = make_flit(1);
        in_g[2] = '0;
        apply_stimulus();
        check_output("full_deflect", WIDE'(port_l_o[FLIT_W-1:0]), WIDE'(in_l[0]));
        check_output("full_l2g_cnt", WIDE'(l2g_cnt_o), WIDE'(FIFO_DEPTH - 1));
        check_output("full_inject_g_ch2", WIDE'(port_g_o[2*FLIT_W +: FLIT_W]), WIDE'(arb_first));
        check_output("full_defl_l", WIDE'(defl_l_o), WIDE'(exp_defl(9)));

        $display("[TB] random traffic with occasional reset");
        for (int c = 0; c < 400; c++) begin
            rst = (c == 200) || ($urandom_range(0, 149) == 0);
            randomize_inputs();
            apply_stimulus();
        end
        rst = 1'b0;

        $display("[TB] forcing global deflections toward saturation");
        for (int c = 0; c < 16500; c++) begin
            for (int k = 0; k < N_LOCAL; k++) in_l[k] = make_flit(RING_ID);
            for (int k = 0; k < N_GLOBAL; k++) in_g[k] = make_flit(RING_ID);
            apply_stimulus();
        end
        for (int c = 0; c < 3; c++) begin
            apply_stimulus();
            check_output("sat_defl_g", WIDE'(defl_g_o), WIDE'(exp_defl(65535)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
